// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decoded-instruction and next-PC select.
// Latency: n/a (wires only); the fetch unit takes the master side.
// Backpressure: imem_ack stalls fetch; sel_valid releases decode.
interface pc_fetch_unit_if #(
   parameter int AW = 16
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic [31:0]   instr;
   logic [5:0]    opcode;
   logic          instr_valid;
   logic          sel_valid;
   logic [2:0]    pc_sel;
   logic [AW-1:0] jmp_target;
   logic [15:0]   br_offset;
   logic [AW-1:0] reg_target;
   logic [AW-1:0] pc;
   logic          halted;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, halted,
      input  imem_ack, imem_rdata, sel_valid, pc_sel, jmp_target, br_offset, reg_target
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, halted,
      output imem_ack, imem_rdata, sel_valid, pc_sel, jmp_target, br_offset, reg_target
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: FETCH/DECODE/HALT sequencer driving instruction-memory reads.
// Latency: 2 cycles minimum per instruction (ack in first FETCH cycle, select in first DECODE cycle).
// Backpressure: waits indefinitely in FETCH for imem_ack and in DECODE for sel_valid.
// Optional: define PC_FETCH_RETIRE_CNT_EN to add the 32-bit retired_cnt output.
module pc_fetch_unit #(
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst_n,
`ifdef PC_FETCH_RETIRE_CNT_EN
   output logic [31:0]    retired_cnt,
`endif
   pc_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {FETCH, DECODE, HALT} state_t;

   state_t        state;
   logic [AW-1:0] pc_q;
   logic [31:0]   instr_q;
   logic          req_q;
   logic          valid_q;
   logic          halted_q;
   logic [AW-1:0] br_ext;
   logic [AW-1:0] next_pc;

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.halted      = halted_q;

   // Next-PC mux; unused select codes 5-7 fall back to sequential.
   always_comb begin
      br_ext  = AW'($signed(bus.br_offset));
      next_pc = pc_q + AW'(1);
      case (bus.pc_sel)
         3'd0:    next_pc = bus.jmp_target;
         3'd1:    next_pc = pc_q + br_ext;
         3'd2:    next_pc = bus.reg_target;
         3'd4:    next_pc = pc_q;
         default: next_pc = pc_q + AW'(1);
      endcase
   end

   // Sequencer FSM with registered request/valid/halted outputs.
   // imem_req rises one edge after reset release and is only honoured while high,
   // so an ack seen before the first request is not mistaken for read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (req_q && bus.imem_ack) begin
                  instr_q <= bus.imem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state   <= DECODE;
               end else begin
                  req_q <= 1'b1;
               end
            end
            DECODE: begin
               if (bus.sel_valid) begin
                  pc_q    <= next_pc;
                  valid_q <= 1'b0;
                  if (bus.pc_sel == 3'd4) begin
                     halted_q <= 1'b1;
                     state    <= HALT;
                  end else begin
                     req_q <= 1'b1;
                     state <= FETCH;
                  end
               end
            end
            default: begin
               req_q    <= 1'b0;
               valid_q  <= 1'b0;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef PC_FETCH_RETIRE_CNT_EN
   // Count every resolved instruction, including the one that halts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= '0;
      end else if (state == DECODE && bus.sel_valid) begin
         retired_cnt <= retired_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, fetch stalls, next-PC selects, wrap, halt, reset abort.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench drives imem_ack and sel_valid directly.
module tb_pc_fetch_unit;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
`ifdef PC_FETCH_RETIRE_CNT_EN
   logic [31:0] retired_cnt;
`endif

   pc_fetch_unit_if #(.AW(16)) bus ();

   pc_fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef PC_FETCH_RETIRE_CNT_EN
      .retired_cnt (retired_cnt),
`endif
      .bus         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] w);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = w;
      step();
      bus.imem_ack   = 1'b0;
   endtask

   task automatic do_decode(input logic [2:0] sel, input logic [15:0] jt,
                            input logic [15:0] off, input logic [15:0] rt);
      bus.sel_valid  = 1'b1;
      bus.pc_sel     = sel;
      bus.jmp_target = jt;
      bus.br_offset  = off;
      bus.reg_target = rt;
      step();
      bus.sel_valid  = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.sel_valid = 1'b0; bus.pc_sel = '0;
      bus.jmp_target = '0; bus.br_offset = '0; bus.reg_target = '0;
      #2;
      n_cmp++;
      if (bus.pc !== 16'h0000 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
          bus.halted !== 1'b0 || bus.instr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_values: pc=%h req=%b iv=%b halt=%b instr=%h required 0000 0 0 0 0",
                  bus.pc, bus.imem_req, bus.instr_valid, bus.halted, bus.instr);
      end
      step(); step();
      rst_n = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h0C00_0000;
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.instr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL first_req: req=%b addr=%h iv=%b required 1 0000 0",
                  bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
   endtask

   task automatic test_first_instr();
      do_fetch(32'h0C00_0000);
      n_cmp++;
      if (bus.instr_valid !== 1'b1 || bus.opcode !== 6'd3 || bus.imem_req !== 1'b0 ||
          bus.instr !== 32'h0C00_0000) begin
         n_err++;
         $display("FAIL decode_opcode: iv=%b opc=%0d req=%b instr=%h required 1 3 0 0c000000",
                  bus.instr_valid, bus.opcode, bus.imem_req, bus.instr);
      end
      do_decode(3'd3, '0, '0, '0);
      n_cmp++;
      if (bus.pc !== 16'h0001 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001 ||
          bus.instr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL seq_next: pc=%h req=%b addr=%h iv=%b required 0001 1 0001 0",
                  bus.pc, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001 || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_%0d: req=%b addr=%h iv=%b required 1 0001 0",
                     i, bus.imem_req, bus.imem_addr, bus.instr_valid);
         end
      end
      do_fetch(32'hFC00_1234);
      // Decode hold: ack toggling and new rdata must not disturb the latched word.
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (bus.instr !== 32'hFC00_1234 || bus.opcode !== 6'h3F || bus.instr_valid !== 1'b1 ||
             bus.imem_req !== 1'b0 || bus.pc !== 16'h0001) begin
            n_err++;
            $display("FAIL decode_hold_%0d: instr=%h opc=%h iv=%b req=%b pc=%h required fc001234 3f 1 0 0001",
                     i, bus.instr, bus.opcode, bus.instr_valid, bus.imem_req, bus.pc);
         end
      end
      bus.imem_ack = 1'b0;
      do_decode(3'd3, '0, '0, '0);
      n_cmp++;
      if (bus.pc !== 16'h0002) begin
         n_err++;
         $display("FAIL after_hold_pc: pc=%h required 0002", bus.pc);
      end
   endtask

   task automatic test_branch_wrap();
      do_fetch(32'h1); do_decode(3'd0, 16'h0010, '0, '0);
      do_fetch(32'h2); do_decode(3'd1, '0, 16'hFFFC, '0);
      n_cmp++;
      if (bus.pc !== 16'h000C) begin
         n_err++;
         $display("FAIL branch_back: pc=%h required 000c", bus.pc);
      end
      do_fetch(32'h3); do_decode(3'd1, '0, 16'h0007, '0);
      n_cmp++;
      if (bus.pc !== 16'h0013) begin
         n_err++;
         $display("FAIL branch_fwd: pc=%h required 0013", bus.pc);
      end
      do_fetch(32'h4); do_decode(3'd0, 16'h0002, '0, '0);
      do_fetch(32'h5); do_decode(3'd1, '0, 16'hFFFC, '0);
      n_cmp++;
      if (bus.pc !== 16'hFFFE) begin
         n_err++;
         $display("FAIL branch_wrap: pc=%h required fffe", bus.pc);
      end
      do_fetch(32'h6); do_decode(3'd0, 16'hFFFF, '0, '0);
      do_fetch(32'h7); do_decode(3'd3, '0, '0, '0);
      n_cmp++;
      if (bus.pc !== 16'h0000 || bus.imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL seq_wrap: pc=%h addr=%h required 0000 0000", bus.pc, bus.imem_addr);
      end
   endtask

   task automatic test_jumps();
      do_fetch(32'h8); do_decode(3'd0, 16'h0123, 16'h0500, 16'h0999);
      n_cmp++;
      if (bus.pc !== 16'h0123) begin
         n_err++;
         $display("FAIL jump_abs: pc=%h required 0123", bus.pc);
      end
      do_fetch(32'h9); do_decode(3'd2, 16'h0777, 16'h0500, 16'h0456);
      n_cmp++;
      if (bus.pc !== 16'h0456) begin
         n_err++;
         $display("FAIL jump_reg: pc=%h required 0456", bus.pc);
      end
      do_fetch(32'hA); do_decode(3'd6, 16'h0777, 16'h0500, 16'h0999);
      n_cmp++;
      if (bus.pc !== 16'h0457) begin
         n_err++;
         $display("FAIL sel6_seq: pc=%h required 0457", bus.pc);
      end
      do_fetch(32'hB); do_decode(3'd7, 16'h0777, 16'h0500, 16'h0999);
      n_cmp++;
      if (bus.pc !== 16'h0458) begin
         n_err++;
         $display("FAIL sel7_seq: pc=%h required 0458", bus.pc);
      end
   endtask

   task automatic test_back_to_back();
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h0400_0000;
      bus.sel_valid = 1'b1;
      bus.pc_sel = 3'd3;
      for (int i = 0; i < 8; i++) step();
      bus.imem_ack = 1'b0;
      bus.sel_valid = 1'b0;
      n_cmp++;
      if (bus.pc !== 16'h045C || bus.imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL back_to_back: pc=%h req=%b required 045c 1", bus.pc, bus.imem_req);
      end
   endtask

   task automatic test_halt();
      do_fetch(32'h1000_0000); do_decode(3'd4, 16'h0111, 16'h0001, 16'h0222);
      n_cmp++;
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
          bus.pc !== 16'h045C) begin
         n_err++;
         $display("FAIL halt_enter: halt=%b req=%b iv=%b pc=%h required 1 0 0 045c",
                  bus.halted, bus.imem_req, bus.instr_valid, bus.pc);
      end
      bus.imem_ack = 1'b1; bus.sel_valid = 1'b1; bus.pc_sel = 3'd0; bus.jmp_target = 16'h0333;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
             bus.pc !== 16'h045C) begin
            n_err++;
            $display("FAIL halt_stay_%0d: halt=%b req=%b iv=%b pc=%h required 1 0 0 045c",
                     i, bus.halted, bus.imem_req, bus.instr_valid, bus.pc);
         end
      end
      bus.imem_ack = 1'b0; bus.sel_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (bus.pc !== 16'h0000 || bus.halted !== 1'b0 || bus.imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL halt_reset: pc=%h halt=%b req=%b required 0000 0 0",
                  bus.pc, bus.halted, bus.imem_req);
      end
      step();
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL resume_fetch: req=%b addr=%h required 1 0000", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid_decode();
      do_fetch(32'hABCD_0001);
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_decode: instr=%h iv=%b req=%b required 00000000 0 0",
                  bus.instr, bus.instr_valid, bus.imem_req);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

`ifdef PC_FETCH_RETIRE_CNT_EN
   task automatic test_retire_cnt();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         do_fetch(32'h0); do_decode(3'd3, '0, '0, '0);
      end
      do_fetch(32'h0); do_decode(3'd4, '0, '0, '0);
      n_cmp++;
      if (retired_cnt !== 32'd11) begin
         n_err++;
         $display("FAIL retire_11: cnt=%0d required 11", retired_cnt);
      end
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_fetch(32'h0); do_decode(3'd3, '0, '0, '0);
      end
      do_fetch(32'h0);
      n_cmp++;
      if (retired_cnt !== 32'd3) begin
         n_err++;
         $display("FAIL retire_3: cnt=%0d required 3", retired_cnt);
      end
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (retired_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL retire_reset: cnt=%0d required 0", retired_cnt);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_first_instr();
      test_wait_states();
      test_branch_wrap();
      test_jumps();
      test_back_to_back();
      test_halt();
      test_reset_mid_decode();
`ifdef PC_FETCH_RETIRE_CNT_EN
      test_retire_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past 200000 time units, required completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter AW, default 16, program-counter and instruction-address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  AW  read address; equals pc while imem_req=1.
REQ-007 imem_ack  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr  output  32  latched instruction word.
REQ-010 opcode  output  6  instr[31:26], driven to the control unit.
REQ-011 instr_valid  output  1  instr/opcode held stable for decode.
REQ-012 sel_valid  input  1  control unit's next-PC select is valid this cycle.
REQ-013 pc_sel  input  3  next-PC select: 0 absolute jump, 1 branch taken, 2 jump register, 3 sequential, 4 halt.
REQ-014 jmp_target  input  AW  absolute target for pc_sel=0.
REQ-015 br_offset  input  16  signed word offset for pc_sel=1.
REQ-016 reg_target  input  AW  register-sourced target for pc_sel=2.
REQ-017 pc  output  AW  current program counter.
REQ-018 halted  output  1  core stopped.

Function
REQ-019 FSM states: FETCH, DECODE, HALT; a single registered state.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, latch imem_rdata into instr and move to DECODE next cycle.
REQ-021 FETCH with imem_ack=0: hold imem_req and imem_addr unchanged, with no limit on wait cycles.
REQ-022 DECODE: imem_req=0, instr_valid=1; instr and opcode remain stable until sel_valid=1.
REQ-023 DECODE with sel_valid=1: update pc per pc_sel at that edge and go to FETCH; for pc_sel=4 go to HALT with pc unchanged.
REQ-024 Next-PC values: sel 0 jmp_target; 1 pc + sign-extended br_offset; 2 reg_target; 3 pc+1; all modulo 2^AW.
REQ-025 Wrap-around: pc=2^AW-1 with sel 3 yields 0; a negative offset below 0 wraps likewise.
REQ-026 pc_sel values 5-7 are treated as 3 (sequential).
REQ-027 imem_ack is ignored outside FETCH; sel_valid is ignored outside DECODE.
REQ-028 HALT: imem_req=0, instr_valid=0, halted=1; HALT is left only by reset.
REQ-029 Minimum instruction period is 2 cycles (ack in first FETCH cycle, sel_valid in first DECODE cycle).

Reset
REQ-030 On rst_n=0, immediately and asynchronously: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, halted=0, imem_req=0.
REQ-031 imem_req first asserts in the first clk edge after rst_n deasserts; assertion mid-fetch or mid-decode discards the in-flight instruction.

Configuration
REQ-032 Macro PC_FETCH_RETIRE_CNT_EN: when defined, add output retired_cnt (32 bits), reset 0, incremented on each DECODE cycle with sel_valid=1, including halt, wrapping at 2^32.
REQ-033 Without PC_FETCH_RETIRE_CNT_EN: no retired_cnt port and no counter logic.

Verification
REQ-034 Reset release, imem_ack=1 at once, rdata=0x0C000000, sel 3 -> opcode=3 in DECODE, pc 0->1, imem_addr=1 in next FETCH.
REQ-035 imem_ack held low 5 cycles -> imem_req=1, imem_addr constant all 5 cycles, instr_valid=0.
REQ-036 pc=0x0010, sel 1, br_offset=0xFFFC -> pc=0x000C; pc=0xFFFF, sel 3 -> pc=0x0000.
REQ-037 sel 0 with jmp_target=0x0123 -> pc=0x0123; sel 2 with reg_target=0x0456 -> pc=0x0456; sel 6 -> pc+1.
REQ-038 sel 4 -> halted=1, imem_req=0 permanently, pc frozen; rst_n pulse -> pc=RESET_PC, fetching resumes.
REQ-039 With PC_FETCH_RETIRE_CNT_EN: 10 instructions then halt -> retired_cnt=11; rst_n low mid-DECODE -> retired_cnt=0.
